// File: rtl/calc_pkg.sv
// Shared constants for the calculator: command codes, ULA and register control
// codes, and the sequencer state encoding.
package calc_pkg;

    localparam logic [3:0] CMD_CLR   = 4'd0;
    localparam logic [3:0] CMD_CLRLD = 4'd1;
    localparam logic [3:0] CMD_LOADX = 4'd2;
    localparam logic [3:0] CMD_ADD   = 4'd3;
    localparam logic [3:0] CMD_SUB   = 4'd4;
    localparam logic [3:0] CMD_MULT  = 4'd5;
    localparam logic [3:0] CMD_DIV   = 4'd6;
    localparam logic [3:0] CMD_MIN   = 4'd7;
    localparam logic [3:0] CMD_MAX   = 4'd8;
    localparam logic [3:0] CMD_DISP  = 4'd9;

    localparam logic [2:0] ULA_ADD   = 3'd0;
    localparam logic [2:0] ULA_SUB   = 3'd1;
    localparam logic [2:0] ULA_MENOR = 3'd2;
    localparam logic [2:0] ULA_MAIOR = 3'd3;

    localparam logic [2:0] REG_HOLD  = 3'd0;
    localparam logic [2:0] REG_RESET = 3'd1;
    localparam logic [2:0] REG_LOAD  = 3'd2;
    localparam logic [2:0] REG_SHL   = 3'd3;
    localparam logic [2:0] REG_SHR   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SHIFT,
        S_ABORT,
        S_ERR
    } seq_state_t;

endpackage

// File: rtl/calc_cmd_decode.sv
// Combinational command lookup: single-cycle micro-op, legality and whether the
// command is a multi-step shift candidate.
module calc_cmd_decode
    import calc_pkg::*;
(
    input  logic [3:0] cmd,
    output logic [2:0] ula,
    output logic [2:0] x,
    output logic [2:0] y,
    output logic [2:0] z,
    output logic       legal,
    output logic       is_shift
);

    always_comb begin
        ula      = ULA_ADD;
        x        = REG_HOLD;
        y        = REG_HOLD;
        z        = REG_HOLD;
        legal    = 1'b1;
        is_shift = 1'b0;
        case (cmd)
            CMD_CLR: begin
                x = REG_RESET;
                y = REG_RESET;
                z = REG_RESET;
            end
            CMD_CLRLD: begin
                x = REG_LOAD;
                y = REG_RESET;
                z = REG_RESET;
            end
            CMD_LOADX: x = REG_LOAD;
            CMD_ADD, CMD_SUB, CMD_MIN, CMD_MAX: begin
                ula = (cmd == CMD_SUB) ? ULA_SUB :
                      (cmd == CMD_MIN) ? ULA_MENOR :
                      (cmd == CMD_MAX) ? ULA_MAIOR : ULA_ADD;
                x = REG_LOAD;
                y = REG_LOAD;
            end
            CMD_DISP: z = REG_LOAD;
            // Zero-shift form; the sequencer overrides this when shamt > 0
            CMD_MULT, CMD_DIV: begin
                x        = REG_LOAD;
                is_shift = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle command sequencer: accepts commands over valid/ready and issues
// registered ULA/X/Y/Z micro-ops, with shift-based MULT/DIV, error and abort.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter  int MAX_SHIFT = 8,
    localparam int SHAMT_W   = $clog2(MAX_SHIFT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmdValidSequencer,
    input  logic [3:0]         cmdSequencer,
    input  logic [SHAMT_W-1:0] shamtSequencer,
    input  logic               abortSequencer,
    output logic               cmdReadySequencer,
    output logic [2:0]         tULASequencer,
    output logic [2:0]         tXSequencer,
    output logic [2:0]         tYSequencer,
    output logic [2:0]         tZSequencer,
    output logic               busySequencer,
    output logic               doneSequencer,
    output logic               errSequencer
);

    seq_state_t         state, next_state;
    logic [SHAMT_W-1:0] count, next_count, shamt_eff;
    logic [3:0]         cmd_q;
    logic [2:0]         next_ula, next_x, next_y, next_z;
    logic               next_done, next_err, accept;
    logic [2:0]         dec_ula, dec_x, dec_y, dec_z;
    logic               dec_legal, dec_is_shift;

    function automatic logic [SHAMT_W-1:0] clamp_shamt(input logic [SHAMT_W-1:0] s);
        return (s > SHAMT_W'(MAX_SHIFT)) ? SHAMT_W'(MAX_SHIFT) : s;
    endfunction

    calc_cmd_decode u_decode (
        .cmd      (cmdSequencer),
        .ula      (dec_ula),
        .x        (dec_x),
        .y        (dec_y),
        .z        (dec_z),
        .legal    (dec_legal),
        .is_shift (dec_is_shift)
    );

    assign cmdReadySequencer = (state == S_IDLE) && !abortSequencer;
    assign accept            = cmdValidSequencer && cmdReadySequencer;
    assign shamt_eff         = clamp_shamt(shamtSequencer);
    assign busySequencer     = (state != S_IDLE);

    // Outputs are computed for the state being entered, so they register
    // alongside it and appear in the cycle after the deciding edge.
    always_comb begin
        next_state = S_IDLE;
        next_count = '0;
        next_ula   = ULA_ADD;
        next_x     = REG_HOLD;
        next_y     = REG_HOLD;
        next_z     = REG_HOLD;
        next_done  = 1'b0;
        next_err   = 1'b0;
        if (abortSequencer) begin
            next_state = S_ABORT;
            next_x     = REG_RESET;
            next_y     = REG_RESET;
            next_z     = REG_RESET;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!dec_legal) begin
                            next_state = S_ERR;
                            next_err   = 1'b1;
                        end else if (dec_is_shift && (shamt_eff != '0)) begin
                            next_state = S_SHIFT;
                            next_count = shamt_eff;
                            next_x     = REG_LOAD;
                            next_y     = (cmdSequencer == CMD_MULT) ? REG_SHL : REG_SHR;
                            next_done  = (shamt_eff == SHAMT_W'(1));
                        end else begin
                            next_state = S_EXEC;
                            next_ula   = dec_ula;
                            next_x     = dec_x;
                            next_y     = dec_y;
                            next_z     = dec_z;
                            next_done  = 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    if (count > SHAMT_W'(1)) begin
                        next_state = S_SHIFT;
                        next_count = count - SHAMT_W'(1);
                        next_y     = (cmd_q == CMD_MULT) ? REG_SHL : REG_SHR;
                        next_done  = (count == SHAMT_W'(2));
                    end
                end
                default: next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            count         <= '0;
            tULASequencer <= ULA_ADD;
            tXSequencer   <= REG_HOLD;
            tYSequencer   <= REG_HOLD;
            tZSequencer   <= REG_HOLD;
            doneSequencer <= 1'b0;
            errSequencer  <= 1'b0;
        end else begin
            state         <= next_state;
            count         <= next_count;
            tULASequencer <= next_ula;
            tXSequencer   <= next_x;
            tYSequencer   <= next_y;
            tZSequencer   <= next_z;
            doneSequencer <= next_done;
            errSequencer  <= next_err;
        end
    end

    always_ff @(posedge clk) begin
        if (accept)
            cmd_q <= cmdSequencer;
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: each issued command queues its expected
// per-cycle outputs, which are popped and compared on the falling edge.
module tb_calc_sequencer;

    localparam int SHAMT_W = 4;

    localparam logic [3:0] C_CLR = 4'd0, C_CLRLD = 4'd1, C_LOADX = 4'd2, C_ADD = 4'd3,
                           C_SUB = 4'd4, C_MULT = 4'd5, C_DIV = 4'd6, C_MIN = 4'd7,
                           C_MAX = 4'd8, C_DISP = 4'd9;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cmdValidSequencer;
    logic [3:0]         cmdSequencer;
    logic [SHAMT_W-1:0] shamtSequencer;
    logic               abortSequencer;
    logic               cmdReadySequencer;
    logic [2:0]         tULASequencer, tXSequencer, tYSequencer, tZSequencer;
    logic               busySequencer, doneSequencer, errSequencer;

    int vectors    = 0;
    int miscompares = 0;

    logic [15:0] exp_q[$];
    logic        abort_q[$];
    string       tag_q[$];

    calc_sequencer #(.MAX_SHIFT(8)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cmdValidSequencer (cmdValidSequencer),
        .cmdSequencer      (cmdSequencer),
        .shamtSequencer    (shamtSequencer),
        .abortSequencer    (abortSequencer),
        .cmdReadySequencer (cmdReadySequencer),
        .tULASequencer     (tULASequencer),
        .tXSequencer       (tXSequencer),
        .tYSequencer       (tYSequencer),
        .tZSequencer       (tZSequencer),
        .busySequencer     (busySequencer),
        .doneSequencer     (doneSequencer),
        .errSequencer      (errSequencer)
    );

    always #5 clk = ~clk;

    // Packed view: {ula, x, y, z, done, err, busy, ready}
    function automatic logic [15:0] pack(input logic [2:0] ula, input logic [2:0] x,
                                         input logic [2:0] y, input logic [2:0] z,
                                         input logic done, input logic err,
                                         input logic busy, input logic ready);
        return {ula, x, y, z, done, err, busy, ready};
    endfunction

    function automatic logic [15:0] observed();
        return {tULASequencer, tXSequencer, tYSequencer, tZSequencer,
                doneSequencer, errSequencer, busySequencer, cmdReadySequencer};
    endfunction

    task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h {ula,x,y,z,done,err,busy,ready}", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic abort, input logic [15:0] exp);
        tag_q.push_back(tag);
        abort_q.push_back(abort);
        exp_q.push_back(exp);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cmdValidSequencer = 1'b0;
            abortSequencer    = abort_q.pop_front();
            #1;
            check_vec(tag_q.pop_front(), observed(), exp_q.pop_front());
        end
    endtask

    task automatic issue(input string tag, input logic [3:0] cmd, input logic [SHAMT_W-1:0] shamt);
        @(negedge clk);
        cmdValidSequencer = 1'b1;
        cmdSequencer      = cmd;
        shamtSequencer    = shamt;
        #1;
        check_vec({tag, "_ready"}, {15'd0, cmdReadySequencer}, 16'd1);
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] cmd, input logic [SHAMT_W-1:0] shamt);
        int k;
        if (cmd > 4'd9) begin
            push({tag, "_err"}, 1'b0, pack(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0));
        end else if ((cmd == C_MULT || cmd == C_DIV) && shamt != 0) begin
            k = (shamt > 8) ? 8 : int'(shamt);
            for (int i = 1; i <= k; i++)
                push($sformatf("%s_shift%0d", tag, i), 1'b0,
                     pack(3'd0, (i == 1) ? 3'd2 : 3'd0, (cmd == C_MULT) ? 3'd3 : 3'd4,
                          3'd0, i == k, 1'b0, 1'b1, 1'b0));
        end else begin
            case (cmd)
                C_CLR:   push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd1, 3'd1, 3'd1, 1, 0, 1, 0));
                C_CLRLD: push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd2, 3'd1, 3'd1, 1, 0, 1, 0));
                C_LOADX: push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd2, 3'd0, 3'd0, 1, 0, 1, 0));
                C_ADD:   push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd2, 3'd2, 3'd0, 1, 0, 1, 0));
                C_SUB:   push({tag, "_exec"}, 1'b0, pack(3'd1, 3'd2, 3'd2, 3'd0, 1, 0, 1, 0));
                C_MIN:   push({tag, "_exec"}, 1'b0, pack(3'd2, 3'd2, 3'd2, 3'd0, 1, 0, 1, 0));
                C_MAX:   push({tag, "_exec"}, 1'b0, pack(3'd3, 3'd2, 3'd2, 3'd0, 1, 0, 1, 0));
                C_DISP:  push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd0, 3'd0, 3'd2, 1, 0, 1, 0));
                default: push({tag, "_exec"}, 1'b0, pack(3'd0, 3'd2, 3'd0, 3'd0, 1, 0, 1, 0));
            endcase
        end
        push({tag, "_idle"}, 1'b0, pack(3'd0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 1));
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] cmd, input logic [SHAMT_W-1:0] shamt);
        issue(tag, cmd, shamt);
        expect_cmd(tag, cmd, shamt);
        drain();
    endtask

    localparam logic [15:0] IDLE_V  = 16'h0001;
    localparam logic [15:0] ABORT_V = 16'b000_001_001_001_0_0_1_0;

    initial begin
        rst_n             = 1'b0;
        cmdValidSequencer = 1'b0;
        cmdSequencer      = 4'd0;
        shamtSequencer    = '0;
        abortSequencer    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("reset_state", observed(), IDLE_V);

        run_cmd("clr", C_CLR, 4'd0);
        run_cmd("mult3", C_MULT, 4'd3);
        run_cmd("div12", C_DIV, 4'd12);
        run_cmd("div0", C_DIV, 4'd0);
        run_cmd("mult0", C_MULT, 4'd0);
        run_cmd("mult1", C_MULT, 4'd1);
        run_cmd("clrld", C_CLRLD, 4'd0);
        run_cmd("loadx", C_LOADX, 4'd7);
        run_cmd("add", C_ADD, 4'd0);
        run_cmd("sub", C_SUB, 4'd0);
        run_cmd("min", C_MIN, 4'd0);
        run_cmd("max", C_MAX, 4'd0);
        run_cmd("disp", C_DISP, 4'd0);
        run_cmd("ill12", 4'd12, 4'd0);
        run_cmd("ill15", 4'd15, 4'd3);

        // Abort on the 2nd cycle of MULT shamt=5
        issue("abort_mult", C_MULT, 4'd5);
        push("abort_mult_s1", 1'b0, pack(3'd0, 3'd2, 3'd3, 3'd0, 0, 0, 1, 0));
        push("abort_mult_s2", 1'b1, pack(3'd0, 3'd0, 3'd3, 3'd0, 0, 0, 1, 0));
        push("abort_mult_ab", 1'b0, ABORT_V);
        for (int i = 0; i < 4; i++)
            push($sformatf("abort_mult_after%0d", i), 1'b0, IDLE_V);
        drain();

        // Abort with a command in IDLE: not accepted, abort held two edges
        @(negedge clk);
        cmdValidSequencer = 1'b1;
        cmdSequencer      = C_ADD;
        abortSequencer    = 1'b1;
        #1;
        check_vec("abort_idle_ready", {15'd0, cmdReadySequencer}, 16'd0);
        push("abort_idle_ab1", 1'b1, ABORT_V);
        push("abort_idle_ab2", 1'b0, ABORT_V);
        push("abort_idle_after0", 1'b0, IDLE_V);
        push("abort_idle_after1", 1'b0, IDLE_V);
        drain();

        // Asynchronous reset mid-SHIFT
        issue("rst_mult", C_MULT, 4'd5);
        push("rst_mult_s1", 1'b0, pack(3'd0, 3'd2, 3'd3, 3'd0, 0, 0, 1, 0));
        push("rst_mult_s2", 1'b0, pack(3'd0, 3'd0, 3'd3, 3'd0, 0, 0, 1, 0));
        drain();
        #2 rst_n = 1'b0;
        #1;
        check_vec("rst_mid_shift", observed(), IDLE_V);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_vec("rst_release", observed(), IDLE_V);
        run_cmd("add_after_rst", C_ADD, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Registered, multi-cycle command sequencer for the calculator datapath. It accepts 4-bit calculator commands over a valid/ready handshake and emits per-cycle ULA and register micro-ops (X, Y, Z). MULT and DIV run as parametrised multi-step power-of-two shifts, and the block adds illegal-command flagging and an abort path. It sits between the keypad/command front end and the ULA/register datapath.

## Interface
- MAX_SHIFT, 8, largest shift count accepted for MULT/DIV; sets SHAMT_W = $clog2(MAX_SHIFT+1)
- clk  in  1  system clock; one clock domain; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- cmdValidSequencer  in  1  command present
- cmdSequencer  in  4  command code (CLR..DISP, 0000..1001)
- shamtSequencer  in  SHAMT_W  shift count for MULT/DIV; ignored otherwise
- abortSequencer  in  1  abort current work and clear registers
- cmdReadySequencer  out  1  block can accept a command this cycle
- tULASequencer  out  3  ULA operation code
- tXSequencer, tYSequencer, tZSequencer  out  3 each  register control codes (HOLD/RESET/LOAD/SHL/SHR)
- busySequencer  out  1  state != IDLE
- doneSequencer  out  1  one-cycle pulse on the final micro-op of a command
- errSequencer  out  1  one-cycle pulse on an illegal command

## Operation
- States: IDLE, EXEC, SHIFT, ABORT, ERR.
- Accept: rising edge with cmdValidSequencer & cmdReadySequencer. cmdReadySequencer = (state==IDLE) & !abortSequencer. Command and shamt are latched on accept.
- Outside EXEC/SHIFT/ABORT, micro-op outputs are ULA=ADD and X/Y/Z=HOLD.
- From IDLE on accept:
  - Codes 1010..1111 -> ERR.
  - MULT/DIV with shamt>0 -> SHIFT, count=min(shamt, MAX_SHIFT).
  - Everything else, including MULT/DIV with shamt=0 -> EXEC.
- EXEC (1 cycle): drive the single-cycle micro-op for the command, assert done, -> IDLE.
  - CLR: ADD, X/Y/Z RESET.
  - CLRLD: ADD, X LOAD, Y/Z RESET.
  - LOADX: ADD, X LOAD, Y/Z HOLD.
  - ADD / SUB / MIN / MAX: ULA ADD / SUB / MENOR / MAIOR respectively, X LOAD, Y LOAD, Z HOLD.
  - DISP: ADD, X/Y HOLD, Z LOAD.
  - MULT/DIV with shamt=0: ADD, X LOAD, Y HOLD, Z HOLD.
- SHIFT (count cycles): each cycle drives ULA ADD, Y SHL (MULT) or SHR (DIV), Z HOLD.
  - X is LOAD on the first cycle and HOLD on the rest.
  - Count decrements each cycle; the cycle with count==1 asserts done, then -> IDLE.
- ERR (1 cycle): err pulse, micro-ops idle, no done, -> IDLE.
- ABORT (1 cycle): ULA ADD, X/Y/Z RESET, no done, -> IDLE.
- Abort priority: abortSequencer=1 at any edge in any state forces -> ABORT.
  - An in-flight SHIFT is discarded and its done is never issued.
  - A simultaneous cmdValid is not accepted, because ready is low.
  - Abort held high holds the block in ABORT, driving RESET every cycle.
- Reset: state IDLE, count 0, ULA=000, X/Y/Z=000 (HOLD), done=0, err=0, busy=0. cmdReady=1 once rst_n is high and abort is low. Reset mid-SHIFT discards the command.

## Timing
- All micro-op, done, err and busy outputs are registered. cmdReady is combinational from state and abort.
- Latency: the micro-op appears in the cycle after the accept edge.
- Throughput:
  - Single-cycle and illegal commands: one per 2 cycles.
  - MULT/DIV with k>0: k cycles busy, next accept possible on cycle k+1 after the accept edge.
- done coincides with the final micro-op cycle. err is never asserted together with done.

## Structure
- Package calc_pkg holds the shared constants: command codes (4-bit), ULA codes (3-bit), register control codes (3-bit, including rShiftLeft/rShiftRight), and the sequencer state enum. The datapath and front end import the same package.
- One sub-module, calc_cmd_decode: combinational command -> {ULA, X, Y, Z, legal, is_shift} lookup, used by EXEC and for the accept decision.
- The top level holds the FSM, the latched command, the SHAMT_W down-counter and the output registers.

## Test plan
- Reset, then CLR accepted -> next cycle tX/tY/tZ=001, done=1, busy=1; following cycle idle outputs and ready=1.
- MULT with shamt=3 -> 3 cycles of tY=011; tX=010 on the first cycle only; done on the 3rd cycle only; ready low for those 3 cycles.
- DIV with shamt=12 (MAX_SHIFT=8) -> exactly 8 cycles of tY=100, then done; DIV with shamt=0 -> one cycle X LOAD, Y HOLD, done.
- Command 1100 -> err pulse one cycle after accept; no done; all micro-ops HOLD.
- abort asserted on the 2nd cycle of MULT shamt=5 -> next cycle X/Y/Z=001, no done ever, IDLE after; abort + cmdValid in IDLE -> command not accepted, ABORT taken.
- rst_n dropped mid-SHIFT -> outputs immediately 000, busy=0; after release, ADD is accepted normally (ULA=000, X/Y LOAD).
